// File: rtl/sdram_port_arbiter_if.sv
// Command/response bus between an SDRAM requester and its server.
// master: drives rd_n/wr_n/addr/be_n/wdata; slave: drives wait_req/valid/rdata.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
);
    logic              rd_n;
    logic              wr_n;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be_n;
    logic [DATA_W-1:0] wdata;
    logic              wait_req;
    logic              valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output rd_n, wr_n, addr, be_n, wdata,
        input  wait_req, valid, rdata
    );

    modport slave (
        input  rd_n, wr_n, addr, be_n, wdata,
        output wait_req, valid, rdata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of one SDRAM controller; read tags
// route in-order za_valid data back to the issuing port.
// Ports: clk, reset_n (sync, active-low); p0/p1 requester buses (slave side);
// ctl controller bus (master side); o_grant one-hot owner, o_pending reads
// outstanding, o_orphan sticky flag for read data with no outstanding tag.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 16,
    parameter int BE_W        = 2,
    parameter int MAX_PENDING = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    sdram_port_arbiter_if.slave          p0,
    sdram_port_arbiter_if.slave          p1,
    sdram_port_arbiter_if.master         ctl,
    output logic [1:0]                   o_grant,
    output logic [$clog2(MAX_PENDING):0] o_pending,
    output logic                         o_orphan
);
    localparam int PW = $clog2(MAX_PENDING);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state, state_n;
    logic   prio, prio_n;

    logic req0, req1, wr0, wr1;
    logic own, sel, cur_req, cur_wr, oth_req;
    logic stall, accept, cur_wait;

    logic [MAX_PENDING-1:0] tag_mem;
    logic [PW-1:0]          wp, rp;
    logic [PW:0]            count;
    logic                   full, empty, push, pop, push_tag, head;

    // Write wins when a port asserts both strobes.
    assign req0 = ~p0.rd_n | ~p0.wr_n;
    assign req1 = ~p1.rd_n | ~p1.wr_n;
    assign wr0  = ~p0.wr_n;
    assign wr1  = ~p1.wr_n;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = ctl.valid & ~empty;
    assign head  = tag_mem[rp];

    // Read data is a pure pass-through; the head tag picks who sees valid.
    assign p0.valid = pop & ~head;
    assign p1.valid = pop & head;
    assign p0.rdata = ctl.rdata;
    assign p1.rdata = ctl.rdata;

    assign o_grant   = {state == OWN1, state == OWN0};
    assign o_pending = count;

    always_comb begin
        state_n   = state;
        prio_n    = prio;
        push      = 1'b0;
        push_tag  = 1'b0;
        ctl.rd_n  = 1'b1;
        ctl.wr_n  = 1'b1;
        ctl.addr  = '0;
        ctl.be_n  = '0;
        ctl.wdata = '0;
        p0.wait_req = 1'b1;
        p1.wait_req = 1'b1;

        own     = (state != IDLE);
        sel     = (state == OWN1);
        cur_req = sel ? req1 : req0;
        cur_wr  = sel ? wr1 : wr0;
        oth_req = sel ? req0 : req1;
        // A read cannot issue without a free tag slot.
        stall    = own & cur_req & ~cur_wr & full;
        accept   = own & cur_req & ~stall & ~ctl.wait_req;
        cur_wait = ctl.wait_req | stall;

        if (own) begin
            if (sel) begin
                ctl.addr    = p1.addr;
                ctl.be_n    = p1.be_n;
                ctl.wdata   = p1.wdata;
                p1.wait_req = cur_wait;
            end else begin
                ctl.addr    = p0.addr;
                ctl.be_n    = p0.be_n;
                ctl.wdata   = p0.wdata;
                p0.wait_req = cur_wait;
            end
            ctl.wr_n = ~cur_wr;
            ctl.rd_n = ~(cur_req & ~cur_wr & ~stall);
        end

        unique case (state)
            IDLE: begin
                if (req0 & req1)
                    state_n = prio ? OWN1 : OWN0;
                else if (req0)
                    state_n = OWN0;
                else if (req1)
                    state_n = OWN1;
            end
            default: begin
                if (!cur_req) begin
                    // Owner withdrew before acceptance.
                    state_n = IDLE;
                end else if (accept) begin
                    prio_n   = ~sel;
                    push     = ~cur_wr;
                    push_tag = sel;
                    if (oth_req)
                        state_n = sel ? OWN0 : OWN1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            tag_mem  <= '0;
            o_orphan <= 1'b0;
        end else begin
            state <= state_n;
            prio  <= prio_n;
            if (push) begin
                tag_mem[wp] <= push_tag;
                wp          <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (ctl.valid & empty)
                o_orphan <= 1'b1;
        end
    end
endmodule
